seg_scan_display: RTL

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg_hex_decode.sv | 18 +
 rtl/seg_scan_display.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: glyph table, segment bit
// positions, blank patterns and a width helper.
package seg_pkg;

    // catode bit 7 is the decimal point, bits 6..0 are segments g..a
    localparam int unsigned SEG_DP_BIT  = 7;
    localparam int unsigned SEG_G_BIT   = 6;
    localparam logic [6:0]  SEG_BLANK   = 7'h7F;
    localparam logic [7:0]  CATODE_OFF  = 8'hFF;

    // Active-low hex glyphs, bit order g..a
    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        logic [6:0] glyph;
        unique case (nibble)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
        endcase
        return glyph;
    endfunction

    // Counter width for a modulus n, never narrower than one bit
    function automatic int unsigned width_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to catode decoder with blanking and decimal point.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    input  logic       dp_i,
    output logic [7:0] catode_o
);

    // Segments follow the glyph unless blanked; dp is independent of blanking
    always_comb begin
        catode_o                      = CATODE_OFF;
        catode_o[SEG_G_BIT:0]         = blank_i ? SEG_BLANK : hex_glyph(nibble_i);
        catode_o[SEG_DP_BIT]          = ~dp_i;
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with tear-free, frame-aligned value updates.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank_lz,
    output logic                  load_ack,
    output logic                  frame_done,
    output logic [DIGITS-1:0]     anode,
    output logic [7:0]            catode
);

    localparam int unsigned     CntW    = width_min1(REFRESH_DIV);
    localparam int unsigned     IdxW    = width_min1(DIGITS);
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

    typedef struct packed {
        logic [4*DIGITS-1:0] data;
        logic [DIGITS-1:0]   dp;
        logic                blank_lz;
    } disp_t;

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    disp_t             pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    disp_t             disp_q, disp_d;
    logic              load_ack_q, load_ack_d;
    logic              frame_done_q, frame_done_d;
    logic [DIGITS-1:0] anode_q, anode_d;
    logic [7:0]        catode_q, catode_d;

    disp_t      incoming;
    logic       step_wrap;
    logic       frame_wrap;
    logic [3:0] cur_nibble;
    logic       cur_blank;
    logic       cur_dp;
    logic       upper_nz;
    logic [7:0] cur_catode;

    assign incoming   = '{data: data, dp: dp_mask, blank_lz: blank_lz};
    assign step_wrap  = enable && (cnt_q == CntLast);
    assign frame_wrap = step_wrap && (idx_q == IdxLast);

    // Refresh counter and digit index; both hold while disabled
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (enable) begin
            if (step_wrap) begin
                cnt_d = '0;
                idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Pending/display registers: the display only changes at the frame boundary
    always_comb begin
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        disp_d       = disp_q;
        load_ack_d   = 1'b0;
        if (frame_wrap) begin
            // a load landing on the boundary bypasses pending entirely
            if (load) begin
                disp_d     = incoming;
                load_ack_d = 1'b1;
            end else if (pend_valid_q) begin
                disp_d     = pend_q;
                load_ack_d = 1'b1;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_d       = incoming;
            pend_valid_d = 1'b1;
        end
    end

    // Select the current digit and decide whether it is a leading zero
    always_comb begin
        cur_nibble = disp_q.data[{idx_q, 2'b00} +: 4];
        cur_dp     = disp_q.dp[idx_q];
        upper_nz   = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if ((i >= int'(idx_q)) && (disp_q.data[i*4 +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
        cur_blank = disp_q.blank_lz && (idx_q != '0) && !upper_nz;
    end

    seg_hex_decode u_decode (
        .nibble_i (cur_nibble),
        .blank_i  (cur_blank),
        .dp_i     (cur_dp),
        .catode_o (cur_catode)
    );

    // Registered drive of the display pins and status pulses
    always_comb begin
        anode_d      = enable ? ~(DIGITS'(1) << idx_q) : '1;
        catode_d     = enable ? cur_catode : CATODE_OFF;
        frame_done_d = frame_wrap;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            disp_q       <= '0;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
            anode_q      <= '1;
            catode_q     <= CATODE_OFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            disp_q       <= disp_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
            anode_q      <= anode_d;
            catode_q     <= catode_d;
        end
    end

    assign load_ack   = load_ack_q;
    assign frame_done = frame_done_q;
    assign anode      = anode_q;
    assign catode     = catode_q;

endmodule
